// File: rtl/uart_tester_ctrl.sv
// uart_tester_ctrl
// ----------------
// Controller between the board I/O and the uart core's byte interfaces.
// It offers three transmit sources selected by 'mode':
//   0 manual  : one byte of tx_byte per press of the send_req button
//   1 echo    : every received byte goes through an echo FIFO and back out
//   2 pattern : incrementing byte pattern (only when UART_TESTER_PATGEN_EN
//               is defined; otherwise behaves like mode 3)
//   3 idle    : nothing is transmitted
// It also keeps RX/TX/overflow statistics for the LEDs.
//
// Optional feature macro: UART_TESTER_PATGEN_EN (pattern generator).
//
// Ports:
//   SYSCLK, SYSRST          clock, asynchronous active-low reset
//   mode[1:0]               transmit source select
//   send_req                raw push-button level (asynchronous)
//   clear                   synchronous statistics clear + FIFO flush
//   tx_byte                 byte sent in manual mode
//   uart_in_ready/valid/data  TX handshake toward the uart core
//   uart_out_valid/data     RX byte pulse from the uart core
//   last_rx                 most recent RX byte
//   rx_count/tx_count       wrapping byte counters
//   ovf_count, overflow     saturating drop counter, sticky drop flag
//   fifo_level              echo FIFO occupancy
//   busy                    TX FSM is in SEND
module uart_tester_ctrl #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 8
) (
    input  logic                          SYSCLK,
    input  logic                          SYSRST,
    input  logic [1:0]                    mode,
    input  logic                          send_req,
    input  logic                          clear,
    input  logic [DATA_W-1:0]             tx_byte,
    input  logic                          uart_in_ready,
    output logic                          uart_in_valid,
    output logic [DATA_W-1:0]             uart_in_data,
    input  logic                          uart_out_valid,
    input  logic [DATA_W-1:0]             uart_out_data,
    output logic [DATA_W-1:0]             last_rx,
    output logic [CNT_W-1:0]              rx_count,
    output logic [CNT_W-1:0]              tx_count,
    output logic [CNT_W-1:0]              ovf_count,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_r, state_nxt_s;
    logic                valid_r;
    logic [DATA_W-1:0]   data_r;
    logic                s1_r, s2_r, s3_r;
    logic                edge_s;
    logic                transfer_s;
    logic                load_s;
    logic [DATA_W-1:0]   load_data_s;
    logic                pop_s;

    logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]       level_r;
    logic                full_s, empty_s;
    logic                wr_req_s, wr_en_s, drop_s;

    logic [DATA_W-1:0]   last_rx_r;
    logic [CNT_W-1:0]    rx_count_r, tx_count_r, ovf_count_r;
    logic                overflow_r;

`ifdef UART_TESTER_PATGEN_EN
    logic [DATA_W-1:0]   pat_r;
    logic                pat_fly_r;
    logic                pat_load_s;
`endif

    assign edge_s     = s2_r & ~s3_r;
    assign transfer_s = valid_r & uart_in_ready;
    assign full_s     = (level_r == FULL_LVL);
    assign empty_s    = (level_r == {LW{1'b0}});

    // Echo writes are discarded while clear flushes the FIFO. A full FIFO
    // still accepts a write when the FSM pops in the same cycle.
    assign wr_req_s = uart_out_valid & (mode == 2'd1) & ~clear;
    assign wr_en_s  = wr_req_s & (~full_s | pop_s);
    assign drop_s   = wr_req_s & full_s & ~pop_s;

    // Two-flop synchroniser for the push-button plus edge register
    always_ff @(posedge SYSCLK or negedge SYSRST) begin
        if (!SYSRST) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= send_req;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // TX FSM next state, byte source selection and FIFO pop request
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        load_data_s = {DATA_W{1'b0}};
        pop_s       = 1'b0;
`ifdef UART_TESTER_PATGEN_EN
        pat_load_s  = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                case (mode)
                    2'd0: begin
                        if (edge_s) begin
                            load_s      = 1'b1;
                            load_data_s = tx_byte;
                            state_nxt_s = SEND;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end
                    2'd1: begin
                        // The FIFO is being flushed under clear, so it
                        // cannot also be popped in that cycle.
                        if (!empty_s && !clear) begin
                            pop_s       = 1'b1;
                            load_s      = 1'b1;
                            load_data_s = mem_r[rd_ptr_r];
                            state_nxt_s = SEND;
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end
`ifdef UART_TESTER_PATGEN_EN
                    2'd2: begin
                        load_s      = 1'b1;
                        pat_load_s  = 1'b1;
                        load_data_s = pat_r;
                        state_nxt_s = SEND;
                    end
`endif
                    default: begin
                        state_nxt_s = IDLE;
                    end
                endcase
            end
            SEND: begin
                if (transfer_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // TX FSM state, valid and data holding registers
    always_ff @(posedge SYSCLK or negedge SYSRST) begin
        if (!SYSRST) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s == SEND);
            if (load_s) begin
                data_r <= load_data_s;
            end
        end
    end

    // Echo FIFO storage, pointers and occupancy
    always_ff @(posedge SYSCLK or negedge SYSRST) begin
        if (!SYSRST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= uart_out_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Statistics; an event coinciding with clear is counted from zero
    always_ff @(posedge SYSCLK or negedge SYSRST) begin
        if (!SYSRST) begin
            last_rx_r   <= {DATA_W{1'b0}};
            rx_count_r  <= {CNT_W{1'b0}};
            tx_count_r  <= {CNT_W{1'b0}};
            ovf_count_r <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
        end else if (clear) begin
            last_rx_r   <= uart_out_valid ? uart_out_data : {DATA_W{1'b0}};
            rx_count_r  <= uart_out_valid ? CNT_W'(1) : {CNT_W{1'b0}};
            tx_count_r  <= transfer_s ? CNT_W'(1) : {CNT_W{1'b0}};
            ovf_count_r <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
        end else begin
            if (uart_out_valid) begin
                last_rx_r  <= uart_out_data;
                rx_count_r <= rx_count_r + CNT_W'(1);
            end
            if (transfer_s) begin
                tx_count_r <= tx_count_r + CNT_W'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (ovf_count_r != {CNT_W{1'b1}}) begin
                    ovf_count_r <= ovf_count_r + CNT_W'(1);
                end
            end
        end
    end

`ifdef UART_TESTER_PATGEN_EN
    // Pattern value; advances only when a pattern byte is transferred
    always_ff @(posedge SYSCLK or negedge SYSRST) begin
        if (!SYSRST) begin
            pat_r     <= {DATA_W{1'b0}};
            pat_fly_r <= 1'b0;
        end else begin
            if (load_s) begin
                pat_fly_r <= pat_load_s;
            end
            if (clear) begin
                pat_r <= {DATA_W{1'b0}};
            end else if (transfer_s && pat_fly_r) begin
                pat_r <= pat_r + DATA_W'(1);
            end
        end
    end
`endif

    assign uart_in_valid = valid_r;
    assign uart_in_data  = data_r;
    assign busy          = (state_r == SEND);
    assign last_rx       = last_rx_r;
    assign rx_count      = rx_count_r;
    assign tx_count      = tx_count_r;
    assign ovf_count     = ovf_count_r;
    assign overflow      = overflow_r;
    assign fifo_level    = level_r;

endmodule
